box_plotter: RTL

BOX_PLOTTER -- requirements
Module: box_plotter

---
 rtl/box_plotter_pkg.sv | 26 ++
 rtl/raster_counter.sv | 66 ++++++
 rtl/box_plotter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/box_plotter_pkg.sv
// Shared game package: screen geometry defaults, coordinate/colour widths,
// the plotter FSM state encoding and a small clip helper. The game datapath
// imports the same package so both sides agree on sizes and encodings.
package box_plotter_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int BOX_SIZE_DEF = 16;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } plot_state_e;

  // True when an unwrapped (one bit wider) pixel position lies on screen.
  function automatic logic in_view(input logic [X_W:0] sx, input logic [Y_W:0] sy,
                                   input logic [X_W:0] w,  input logic [Y_W:0] h);
    return (sx < w) && (sy < h);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major raster position counter for the box plotter.
// Holds the current offset (dx, dy) and the scan limits (W-1, H-1).
//   load    : restart at (0,0) and capture new limits w_m1/h_m1
//   adv     : step one position (dx first, then dy with dx back to 0)
//   dx_next : offset that will be current after this clock edge
//   dy_next : idem for dy
//   last    : current offset is the final position of the scan
module raster_counter
  import box_plotter_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           load,
  input  logic           adv,
  input  logic [X_W-1:0] w_m1,
  input  logic [Y_W-1:0] h_m1,
  output logic [X_W-1:0] dx_next,
  output logic [Y_W-1:0] dy_next,
  output logic           last
);

  localparam logic [X_W-1:0] ONE_X = 1;
  localparam logic [Y_W-1:0] ONE_Y = 1;

  logic [X_W-1:0] dx_q, dx_d, w_q, w_d;
  logic [Y_W-1:0] dy_q, dy_d, h_q, h_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    w_d  = w_q;
    h_d  = h_q;
    if (load) begin
      dx_d = '0;
      dy_d = '0;
      w_d  = w_m1;
      h_d  = h_m1;
    end else if (adv) begin
      if (dx_q == w_q) begin
        dx_d = '0;
        dy_d = dy_q + ONE_Y;
      end else begin
        dx_d = dx_q + ONE_X;
      end
    end
  end

  assign dx_next = dx_d;
  assign dy_next = dy_d;
  assign last    = (dx_q == w_q) && (dy_q == h_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
      w_q  <= '0;
      h_q  <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
      w_q  <= w_d;
      h_q  <= h_d;
    end
  end

endmodule

// File: rtl/box_plotter.sv
// Box plotter: turns one draw command into a stream of pixel writes for the
// VGA adapter, one position per clock. A command either fills a
// BOX_SIZE x BOX_SIZE square at (x_in, y_in) or clears the whole screen.
//
// Ports:
//   clock, resetn          : clock, asynchronous active-low reset
//   start, clear_all       : command request and type
//   x_in, y_in, colour_in  : command origin and colour (sampled with start)
//   busy                   : high while the command emits pixels
//   done                   : one-cycle completion pulse
//   x, y, colour, plot     : registered pixel-write stream
//
// Handshake: start is a request taken on any rising edge where busy=0 (IDLE
// or DONE); all command inputs are sampled on that same edge. While busy=1,
// start is ignored and nothing is queued. The first pixel is on the outputs
// in the cycle right after acceptance; done follows the last pixel cycle.
module box_plotter
  import box_plotter_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             clear_all,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [COL_W-1:0] colour_in,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot
);

  localparam int SW_M1  = SCREEN_W - 1;
  localparam int SH_M1  = SCREEN_H - 1;
  localparam int BOX_M1 = BOX_SIZE - 1;

  localparam logic [X_W:0]   SCR_W_L  = SCREEN_W[X_W:0];
  localparam logic [Y_W:0]   SCR_H_L  = SCREEN_H[Y_W:0];
  localparam logic [X_W-1:0] SCR_W_M1 = SW_M1[X_W-1:0];
  localparam logic [Y_W-1:0] SCR_H_M1 = SH_M1[Y_W-1:0];
  localparam logic [X_W-1:0] BOX_W_M1 = BOX_M1[X_W-1:0];
  localparam logic [Y_W-1:0] BOX_H_M1 = BOX_M1[Y_W-1:0];

  plot_state_e state_q, state_d;

  logic             accept, load, adv, last;
  logic [X_W-1:0]   dx_next;
  logic [Y_W-1:0]   dy_next;
  logic [X_W-1:0]   w_m1;
  logic [Y_W-1:0]   h_m1;

  // Latched command
  logic [X_W-1:0]   org_x_q, org_x_d;
  logic [Y_W-1:0]   org_y_q, org_y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             clr_q, clr_d;

  // Output registers
  logic             busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] colour_q, colour_d;

  // Unwrapped sums so off-screen positions clip instead of wrapping back.
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRAW;
          accept  = 1'b1;
          load    = 1'b1;
        end
      end
      S_DRAW: begin
        if (last) state_d = S_DONE;
        else      adv     = 1'b1;
      end
      S_DONE: begin
        // A start here chains straight into the next command.
        if (start) begin
          state_d = S_DRAW;
          accept  = 1'b1;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ command latch
  always_comb begin
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    col_d   = col_q;
    clr_d   = clr_q;
    if (accept) begin
      clr_d   = clear_all;
      org_x_d = clear_all ? '0 : x_in;
      org_y_d = clear_all ? '0 : y_in;
      col_d   = colour_in;
    end
    w_m1 = clr_d ? SCR_W_M1 : BOX_W_M1;
    h_m1 = clr_d ? SCR_H_M1 : BOX_H_M1;
  end

  raster_counter u_raster (
    .clock   (clock),
    .resetn  (resetn),
    .load    (load),
    .adv     (adv),
    .w_m1    (w_m1),
    .h_m1    (h_m1),
    .dx_next (dx_next),
    .dy_next (dy_next),
    .last    (last)
  );

  // ------------------------------------------------ pixel / status regs
  // Pixel registers are fed from the post-edge position (origin_d + offset
  // after this edge), so the pixel shown matches the state being entered.
  always_comb begin
    sum_x    = {1'b0, org_x_d} + {1'b0, dx_next};
    sum_y    = {1'b0, org_y_d} + {1'b0, dy_next};
    busy_d   = (state_d == S_DRAW);
    done_d   = (state_d == S_DONE);
    plot_d   = (state_d == S_DRAW) && in_view(sum_x, sum_y, SCR_W_L, SCR_H_L);
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (state_d == S_DRAW) begin
      x_d      = sum_x[X_W-1:0];
      y_d      = sum_y[Y_W-1:0];
      colour_d = col_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      org_x_q  <= '0;
      org_y_q  <= '0;
      col_q    <= '0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      col_q    <= col_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule
